// File: rtl/ring_buffer_reader.sv
// rtl/ring_buffer_reader.sv - window reader for the sample ring buffer
// Tracks occupancy, issues credit-limited reads and streams one window per start.
module ring_buffer_reader #(
  parameter int ENTRIES      = 2048,
  parameter int DATA_WIDTH   = 32,
  parameter int WINDOW_SIZE  = 1024,
  parameter int READ_LATENCY = 2,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           shift_trigger_in,
  input  logic                           start_in,
  output logic                           read_trigger_out,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           data_valid_in,
  output logic [DATA_WIDTH-1:0]          m_data_out,
  output logic                           m_valid_out,
  output logic                           m_last_out,
  input  logic                           m_ready_in,
  output logic                           busy_out,
  output logic                           done_out,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy_out,
  output logic                           overflow_out
);

  localparam int OCC_W = $clog2(ENTRIES + 1);
  localparam int REM_W = $clog2(WINDOW_SIZE + 1);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  // Reads issued in the last READ_LATENCY+1 cycles are the most that can be outstanding.
  localparam int IFL_W = $clog2(READ_LATENCY + 2);
  localparam int SUM_W = $clog2(SKID_DEPTH + READ_LATENCY + 3);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [OCC_W-1:0]       occ;
  logic [REM_W-1:0]       remaining;
  logic [IFL_W-1:0]       in_flight;
  logic [CNT_W-1:0]       fifo_count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [DATA_WIDTH-1:0]  fifo_data [SKID_DEPTH];
  logic [SKID_DEPTH-1:0]  fifo_last;
  logic [SUM_W-1:0]       outstanding;
  logic                   rd_issue;
  logic                   push;
  logic                   push_last;
  logic                   pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign outstanding = SUM_W'(in_flight) + SUM_W'(fifo_count);
  assign rd_issue    = (state == ACTIVE) && (remaining != '0) && (occ != '0) &&
                       (outstanding < SUM_W'(SKID_DEPTH));
  assign push        = data_valid_in && (in_flight != '0);
  // Returns come back in issue order, so the final return of a window is the last entry.
  assign push_last   = (remaining == '0) && (in_flight == IFL_W'(1));
  assign pop         = (fifo_count != '0) && m_ready_in;

  assign read_trigger_out = rd_issue;
  assign occupancy_out    = occ;
  assign m_valid_out      = (fifo_count != '0);
  assign m_data_out       = m_valid_out ? fifo_data[rd_ptr] : '0;
  assign m_last_out       = m_valid_out & fifo_last[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      remaining <= '0;
    end else begin
      done_out <= 1'b0;
      if (rd_issue) remaining <= remaining - REM_W'(1);
      case (state)
        IDLE: begin
          if (start_in) begin
            state     <= ACTIVE;
            busy_out  <= 1'b1;
            remaining <= REM_W'(WINDOW_SIZE);
          end
        end
        ACTIVE: begin
          if (pop && m_last_out) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      occ          <= '0;
      overflow_out <= 1'b0;
    end else if (shift_trigger_in && !rd_issue) begin
      if (occ == OCC_W'(ENTRIES)) overflow_out <= 1'b1;
      else                        occ <= occ + OCC_W'(1);
    end else if (rd_issue && !shift_trigger_in) begin
      occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({rd_issue, push})
        2'b10:   in_flight <= in_flight + IFL_W'(1);
        2'b01:   in_flight <= in_flight - IFL_W'(1);
        default: in_flight <= in_flight;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      fifo_data[wr_ptr] <= data_in;
      fifo_last[wr_ptr] <= push_last;
    end
  end

endmodule

// File: tb/tb_ring_buffer_reader.sv
// tb/tb_ring_buffer_reader.sv - self-checking bench for ring_buffer_reader
// Models the ring buffer and its read latency; checks against a queue-based reference.
module tb_ring_buffer_reader;

  localparam int ENTRIES = 16;
  localparam int DW      = 32;
  localparam int WIN     = 8;
  localparam int SKID    = 4;
  localparam int OW      = $clog2(ENTRIES + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          shift = 1'b0;
  logic          start = 1'b0;
  logic          dv = 1'b0;
  logic          m_ready = 1'b1;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] wdata = '0;
  logic          rd, m_valid, m_last, busy, done, overflow;
  logic [DW-1:0] m_data;
  logic [OW-1:0] occ;

  always #5 clk = ~clk;

  ring_buffer_reader #(
    .ENTRIES(ENTRIES), .DATA_WIDTH(DW), .WINDOW_SIZE(WIN),
    .READ_LATENCY(2), .SKID_DEPTH(SKID)
  ) dut (
    .clk_in(clk), .rst_in(rst), .shift_trigger_in(shift), .start_in(start),
    .read_trigger_out(rd), .data_in(din), .data_valid_in(dv),
    .m_data_out(m_data), .m_valid_out(m_valid), .m_last_out(m_last),
    .m_ready_in(m_ready), .busy_out(busy), .done_out(done),
    .occupancy_out(occ), .overflow_out(overflow)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit armed = 1'b0;

  logic [DW-1:0] bufq[$];
  logic [DW-1:0] expq[$];
  logic [DW-1:0] beats[$];
  int occ_m = 0, issued = 0, popped = 0, win_beats = 0;
  int n_rd = 0, first_rd = -1, last_rd = -1, first_val = -1, done_cyc = -1, nlast = 0, ndone = 0;
  bit ovf_m = 0, act = 0, done_m = 0, hold = 0, hold_l = 0, p_v = 0;
  logic [DW-1:0] hold_d = '0, p_d = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, advance the model, then clock.
  task automatic tick();
    bit rt, fire, want_last, nv;
    logic [DW-1:0] pd, nd, ed;
    rt   = (rd === 1'b1);
    fire = (m_valid === 1'b1) && m_ready;
    pd   = '0;
    if (armed) begin
      check("occupancy", 64'(occ), 64'(occ_m));
      check("overflow", 64'(overflow), 64'(ovf_m));
      check("busy", 64'(busy), 64'(act));
      check("done", 64'(done), 64'(done_m));
      check("read_trigger", 64'(rd),
            64'(act && issued < WIN && occ_m > 0 && (issued - popped) < SKID));
      if (hold) begin
        check("hold_valid", 64'(m_valid), 64'(1));
        check("hold_data", 64'(m_data), 64'(hold_d));
        check("hold_last", 64'(m_last), 64'(hold_l));
      end
    end
    if (rt) begin
      if (bufq.size() > 0) pd = bufq.pop_front();
      expq.push_back(pd);
      issued++;
      if (n_rd == 0) first_rd = cyc;
      last_rd = cyc;
      n_rd++;
    end
    if (shift && bufq.size() < ENTRIES) bufq.push_back(wdata);
    if (shift && !rt) begin
      if (occ_m == ENTRIES) ovf_m = 1'b1;
      else occ_m++;
    end else if (rt && !shift) begin
      occ_m--;
    end
    if (m_valid === 1'b1 && first_val < 0) first_val = cyc;
    if (done === 1'b1) begin
      ndone++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    want_last = 1'b0;
    if (fire) begin
      want_last = (win_beats == WIN - 1);
      if (armed) begin
        check("beat_expected", 64'(expq.size() > 0), 64'(1));
        if (expq.size() > 0) begin
          ed = expq.pop_front();
          check("beat_data", 64'(m_data), 64'(ed));
        end
        check("beat_last", 64'(m_last), 64'(want_last));
      end
      beats.push_back(m_data);
      if (m_last === 1'b1) nlast++;
      win_beats++;
      popped++;
    end
    hold   = (m_valid === 1'b1) && !m_ready;
    hold_d = m_data;
    hold_l = m_last;
    done_m = 1'b0;
    if (act && fire && want_last) begin
      act = 1'b0;
      done_m = 1'b1;
    end else if (!act && start) begin
      act = 1'b1;
      issued = 0;
      popped = 0;
      win_beats = 0;
    end
    nv = p_v;
    nd = p_d;
    p_v = rt;
    p_d = pd;
    // The buffer's return pipeline is not reset: stale returns must be dropped by the DUT.
    if (rst) begin
      act = 0; done_m = 0; occ_m = 0; ovf_m = 0; hold = 0;
      issued = 0; popped = 0; win_beats = 0;
      bufq.delete();
      expq.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    dv = nv;
    din = nd;
    shift = 1'b0;
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    armed = 1'b1;
  endtask

  task automatic shift_in(input logic [DW-1:0] v);
    shift = 1'b1;
    wdata = v;
    tick();
  endtask

  task automatic clear_log();
    n_rd = 0; first_rd = -1; last_rd = -1; first_val = -1;
    done_cyc = -1; nlast = 0; ndone = 0;
    beats.delete();
  endtask

  task automatic check_beats(input int base);
    check("beat_count", 64'(beats.size()), 64'(WIN));
    for (int i = 0; i < WIN && i < beats.size(); i++)
      check("beat_order", 64'(beats[i]), 64'(base + i));
  endtask

  task automatic check_all_zero();
    check("zero_read_trigger", 64'(rd), 64'(0));
    check("zero_m_valid", 64'(m_valid), 64'(0));
    check("zero_m_data", 64'(m_data), 64'(0));
    check("zero_m_last", 64'(m_last), 64'(0));
    check("zero_busy", 64'(busy), 64'(0));
    check("zero_done", 64'(done), 64'(0));
    check("zero_occupancy", 64'(occ), 64'(0));
    check("zero_overflow", 64'(overflow), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    rst = 1'b1;
    tick();
    do_reset();
    check_all_zero();

    // Prefilled buffer, full-rate window
    for (int i = 0; i < 12; i++) shift_in(DW'(i));
    clear_log();
    start = 1'b1;
    s = cyc;
    tick();
    repeat (16) tick();
    check("t1_first_read", 64'(first_rd), 64'(s + 1));
    check("t1_last_read", 64'(last_rd), 64'(s + WIN));
    check("t1_reads", 64'(n_rd), 64'(WIN));
    check("t1_first_valid", 64'(first_val), 64'(s + 4));
    check("t1_done_cycle", 64'(done_cyc), 64'(s + WIN + 4));
    check("t1_occupancy", 64'(occ), 64'(4));
    check("t1_lasts", 64'(nlast), 64'(1));
    check_beats(0);

    // Empty buffer, samples trickle in
    do_reset();
    clear_log();
    start = 1'b1;
    tick();
    repeat (3) begin
      check("t2_no_read_empty", 64'(rd), 64'(0));
      tick();
    end
    for (int k = 0; k < WIN; k++) begin
      shift_in(DW'(10 + k));
      check("t2_read_after_shift", 64'(rd), 64'(1));
      tick();
      for (int j = 0; j < 3; j++) begin
        check("t2_no_read_gap", 64'(rd), 64'(0));
        tick();
      end
    end
    repeat (10) tick();
    check_beats(10);
    check("t2_lasts", 64'(nlast), 64'(1));
    check("t2_done", 64'(ndone), 64'(1));

    // Backpressure stalls reads at the credit limit
    do_reset();
    for (int i = 0; i < ENTRIES; i++) shift_in(DW'(100 + i));
    clear_log();
    start = 1'b1;
    tick();
    for (int g = 0; g < 20 && beats.size() == 0; g++) tick();
    check("t3_first_beat", 64'(beats.size() > 0), 64'(1));
    m_ready = 1'b0;
    repeat (20) tick();
    check("t3_stalled_reads", 64'(n_rd), 64'(SKID + 1));
    check("t3_occ_stall", 64'(occ), 64'(ENTRIES - SKID - 1));
    m_ready = 1'b1;
    repeat (20) tick();
    check_beats(100);
    check("t3_lasts", 64'(nlast), 64'(1));
    check("t3_done", 64'(ndone), 64'(1));

    // Shift and read in the same cycle
    do_reset();
    clear_log();
    start = 1'b1;
    tick();
    shift_in(DW'(200));
    check("t4_read", 64'(rd), 64'(1));
    check("t4_occ_one", 64'(occ), 64'(1));
    shift_in(DW'(201));
    check("t4_occ_hold", 64'(occ), 64'(1));
    check("t4_read_again", 64'(rd), 64'(1));
    tick();
    check("t4_occ_drained", 64'(occ), 64'(0));
    for (int i = 2; i < WIN; i++) shift_in(DW'(200 + i));
    repeat (15) tick();
    check_beats(200);

    // Overflow is sticky until reset
    do_reset();
    for (int i = 0; i < ENTRIES + 1; i++) shift_in(DW'(i));
    check("t5_occ_sat", 64'(occ), 64'(ENTRIES));
    check("t5_overflow", 64'(overflow), 64'(1));
    repeat (100) tick();
    check("t5_overflow_sticky", 64'(overflow), 64'(1));
    check("t5_occ_sticky", 64'(occ), 64'(ENTRIES));
    do_reset();
    check("t5_overflow_clear", 64'(overflow), 64'(0));
    check("t5_occ_clear", 64'(occ), 64'(0));

    // Reset with reads outstanding
    for (int i = 0; i < 4; i++) shift_in(DW'(50 + i));
    start = 1'b1;
    tick();
    check("t6_read", 64'(rd), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    check_all_zero();
    repeat (6) begin
      check("t6_no_valid", 64'(m_valid), 64'(0));
      check("t6_not_busy", 64'(busy), 64'(0));
      tick();
    end
    for (int i = 0; i < WIN; i++) shift_in(DW'(300 + i));
    clear_log();
    start = 1'b1;
    tick();
    repeat (20) tick();
    check_beats(300);
    check("t6_lasts", 64'(nlast), 64'(1));

    // Randomized traffic against the reference model
    do_reset();
    clear_log();
    for (int g = 0; g < 4000 && ndone < 6; g++) begin
      m_ready = ($urandom_range(0, 99) < 70);
      if (occ_m < ENTRIES && $urandom_range(0, 99) < 45) begin
        shift = 1'b1;
        wdata = $urandom;
      end
      if ($urandom_range(0, 99) < 8) start = 1'b1;
      tick();
    end
    check("rand_windows", 64'(ndone >= 6), 64'(1));
    m_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
